// File: rtl/branch_sequencer.sv
// branch_sequencer: three-state controller that captures a decoded branch,
// evaluates its condition, and holds the resolved next PC until fetch takes it.
// Also keeps saturating committed-branch / taken-branch counters for debug.
module branch_sequencer #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     instruction,
  input  logic [WIDTH-1:0]     rddata,
  input  logic [WIDTH-1:0]     rsdata,
  input  logic [WIDTH-1:0]     N,
  input  logic [WIDTH-1:0]     pc,
  input  logic [WIDTH-1:0]     target,
  output logic                 busy,
  output logic                 pc_valid,
  input  logic                 pc_ready,
  output logic [WIDTH-1:0]     next_pc,
  output logic                 taken,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] taken_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EVAL   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [1:0]           r_state;
  logic [3:0]           r_cond;
  logic [WIDTH-1:0]     r_rd;
  logic [WIDTH-1:0]     r_rs;
  logic [WIDTH-1:0]     r_n;
  logic [WIDTH-1:0]     r_pc;
  logic [WIDTH-1:0]     r_tgt;
  logic                 r_taken;
  logic [WIDTH-1:0]     r_next_pc;
  logic [CNT_WIDTH-1:0] r_branch_cnt;
  logic [CNT_WIDTH-1:0] r_taken_cnt;
  logic                 w_cond_true;
  logic                 w_handoff;

  // Handshake only counts while a result is actually being presented.
  assign w_handoff = (r_state == S_COMMIT) && pc_ready;

  // Condition evaluation on the captured operands (unsigned compares).
  always_comb begin
    w_cond_true = 1'b0;
    case (r_cond)
      4'b0000: w_cond_true = (r_rd >  r_rs);
      4'b0001: w_cond_true = (r_rd <  r_rs);
      4'b0010: w_cond_true = (r_rd == r_rs);
      4'b0011: w_cond_true = (r_rd != r_rs);
      4'b0100: w_cond_true = (r_rd == '0);
      4'b1000: w_cond_true = (r_rd >  r_n);
      4'b1001: w_cond_true = (r_rd <  r_n);
      4'b1010: w_cond_true = (r_rd == r_n);
      4'b1011: w_cond_true = (r_rd != r_n);
      default: w_cond_true = 1'b0;
    endcase
  end

  // FSM: capture on accept, resolve in EVAL, hold result through COMMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cond    <= '0;
      r_rd      <= '0;
      r_rs      <= '0;
      r_n       <= '0;
      r_pc      <= '0;
      r_tgt     <= '0;
      r_taken   <= 1'b0;
      r_next_pc <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cond  <= {instruction[11], instruction[4:2]};
            r_rd    <= rddata;
            r_rs    <= rsdata;
            r_n     <= N;
            r_pc    <= pc;
            r_tgt   <= target;
            r_state <= S_EVAL;
          end
        end
        S_EVAL: begin
          // Result registers only change here, so they stay put through any stall
          // and keep their last value after handoff.
          r_taken   <= w_cond_true;
          r_next_pc <= w_cond_true ? r_tgt : r_pc + WIDTH'(1);
          r_state   <= S_COMMIT;
        end
        S_COMMIT: begin
          if (pc_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Saturating statistics, bumped once per completed handoff.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_branch_cnt <= '0;
      r_taken_cnt  <= '0;
    end else if (w_handoff) begin
      if (!(&r_branch_cnt))           r_branch_cnt <= r_branch_cnt + CNT_WIDTH'(1);
      if (r_taken && !(&r_taken_cnt)) r_taken_cnt  <= r_taken_cnt + CNT_WIDTH'(1);
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign pc_valid   = (r_state == S_COMMIT);
  assign next_pc    = r_next_pc;
  assign taken      = r_taken;
  assign branch_cnt = r_branch_cnt;
  assign taken_cnt  = r_taken_cnt;

endmodule
